lcd_read_cycle: RTL and testbench

- Generates the HD44780-style LCD read bus cycle: RW high, RS setup, E pulse, then DB[7:0] sampled at the end of E-high.
- Counterpart of the LCD write-cycle sequencer. Sits between the LCD controller FSM and the LCD pins.
- Used for busy-flag/address-counter reads (RS=0) and data RAM reads (RS=1).
- Timing is counted in clk cycles. Defaults assume a 50 MHz clk.

---
 rtl/lcd_read_if.sv | 27 ++
 rtl/lcd_read_cycle.sv | 100 ++++++++++
 tb/tb_lcd_read_cycle.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lcd_read_if.sv
// lcd_read_if: request/response handshake and LCD pin bundle for lcd_read_cycle.
// poll_busy exists only when LCD_READ_BUSY_POLL_EN is defined.
interface lcd_read_if;
    logic       rd_enable;
    logic       rs_in;
`ifdef LCD_READ_BUSY_POLL_EN
    logic       poll_busy;
`endif
    logic [7:0] lcd_db_in;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       E_out;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic       rd_finish;
`ifdef LCD_READ_BUSY_POLL_EN
    modport master (output rd_enable, rs_in, poll_busy, lcd_db_in,
                    input lcd_rs, lcd_rw, E_out, rd_data, busy_flag, rd_finish);
    modport slave  (input rd_enable, rs_in, poll_busy, lcd_db_in,
                    output lcd_rs, lcd_rw, E_out, rd_data, busy_flag, rd_finish);
`else
    modport master (output rd_enable, rs_in, lcd_db_in,
                    input lcd_rs, lcd_rw, E_out, rd_data, busy_flag, rd_finish);
    modport slave  (input rd_enable, rs_in, lcd_db_in,
                    output lcd_rs, lcd_rw, E_out, rd_data, busy_flag, rd_finish);
`endif
endinterface

// File: rtl/lcd_read_cycle.sv
// lcd_read_cycle: HD44780 read bus cycle (RW high, RS setup, E pulse, DB sampled as E falls).
// Optional busy-flag polling loop enabled by defining LCD_READ_BUSY_POLL_EN.
module lcd_read_cycle #(
    parameter int SETUP_CYC  = 3,
    parameter int E_HIGH_CYC = 13,
    parameter int HOLD_CYC   = 2,
    parameter int CNT_W      = 5
) (
    input logic       clk,
    input logic       rst,
    lcd_read_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, DONE} state_t;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam state_t FIRST   = (SETUP_CYC == 0) ? EHIGH : SETUP;
    localparam logic   START_E = (SETUP_CYC == 0);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lcd_rs, lcd_rw, e_out, busy_flag, rd_finish, poll_q, poll_sel;
    logic [7:0]       rd_data;
    logic             again_hold, again_ehigh;
`ifdef LCD_READ_BUSY_POLL_EN
    assign poll_sel = bus.poll_busy;
`else
    assign poll_sel = 1'b0;
`endif
    // lcd_rs doubles as the latched RS of the read in flight
    assign again_hold  = poll_q & ~lcd_rs & rd_data[7];
    assign again_ehigh = poll_q & ~lcd_rs & bus.lcd_db_in[7];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            e_out     <= 1'b0;
            rd_data   <= 8'h00;
            busy_flag <= 1'b0;
            rd_finish <= 1'b0;
            poll_q    <= 1'b0;
        end else begin
            rd_finish <= 1'b0;
            case (state)
                IDLE: if (bus.rd_enable) begin
                    lcd_rs <= bus.rs_in;
                    poll_q <= poll_sel & ~bus.rs_in;
                    lcd_rw <= 1'b1;
                    cnt    <= '0;
                    state  <= FIRST;
                    e_out  <= START_E;
                end
                SETUP: if (cnt == SETUP_LAST) begin
                    cnt   <= '0;
                    state <= EHIGH;
                    e_out <= 1'b1;
                end else cnt <= cnt + 1'b1;
                EHIGH: if (cnt == EHIGH_LAST) begin
                    cnt     <= '0;
                    e_out   <= 1'b0;
                    rd_data <= bus.lcd_db_in;
                    if (!lcd_rs) busy_flag <= bus.lcd_db_in[7];
                    if (HOLD_CYC != 0) state <= HOLD;
                    else if (again_ehigh) begin
                        state <= FIRST;
                        e_out <= START_E;
                    end else begin
                        state     <= DONE;
                        lcd_rw    <= 1'b0;
                        rd_finish <= 1'b1;
                    end
                end else cnt <= cnt + 1'b1;
                HOLD: if (cnt == HOLD_LAST) begin
                    cnt <= '0;
                    if (again_hold) begin
                        state <= FIRST;
                        e_out <= START_E;
                    end else begin
                        state     <= DONE;
                        lcd_rw    <= 1'b0;
                        rd_finish <= 1'b1;
                    end
                end else cnt <= cnt + 1'b1;
                DONE: state <= IDLE;
                default: begin
                    state  <= IDLE;
                    e_out  <= 1'b0;
                    lcd_rw <= 1'b0;
                end
            endcase
        end
    end
    assign bus.lcd_rs    = lcd_rs;
    assign bus.lcd_rw    = lcd_rw;
    assign bus.E_out     = e_out;
    assign bus.rd_data   = rd_data;
    assign bus.busy_flag = busy_flag;
    assign bus.rd_finish = rd_finish;
endmodule

// File: tb/tb_lcd_read_cycle.sv
// tb_lcd_read_cycle: directed self-checking bench for lcd_read_cycle with default timing.
// Cycle k means the interval after the k-th rising edge counted from the request edge.
module tb_lcd_read_cycle;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    lcd_read_if bus();
    lcd_read_cycle dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic do_read(input logic rs, input logic [7:0] db,
                           output int e_cnt, output int e_first, output int e_last,
                           output int rw_cnt, output int rw_first, output int rw_last,
                           output int fin_cnt, output int fin_at, output int rs_bad);
        e_cnt = 0; e_first = -1; e_last = -1; rw_cnt = 0; rw_first = -1; rw_last = -1;
        fin_cnt = 0; fin_at = -1; rs_bad = 0;
        bus.rs_in = rs; bus.lcd_db_in = db; bus.rd_enable = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 0) bus.rd_enable = 1'b0;
            if (bus.E_out) begin e_cnt++; if (e_first < 0) e_first = k; e_last = k; end
            if (bus.lcd_rw) begin
                rw_cnt++; if (rw_first < 0) rw_first = k; rw_last = k;
                if (bus.lcd_rs !== rs) rs_bad++;
            end
            if (bus.rd_finish) begin fin_cnt++; fin_at = k; end
        end
    endtask

    task automatic test_reset;
        bus.rd_enable = 1'b0; bus.rs_in = 1'b0; bus.lcd_db_in = 8'hFF;
`ifdef LCD_READ_BUSY_POLL_EN
        bus.poll_busy = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (bus.E_out !== 1'b0) begin errors++; $display("FAIL reset_e got %b exp 0", bus.E_out); end
        checks++; if (bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", bus.lcd_rw); end
        checks++; if (bus.lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs got %b exp 0", bus.lcd_rs); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.rd_data); end
        checks++; if (bus.busy_flag !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_flag); end
        checks++; if (bus.rd_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", bus.rd_finish); end
        rst = 1'b1;
    endtask

    task automatic test_idle;
        int act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.E_out || bus.lcd_rw || bus.lcd_rs || bus.rd_finish || bus.busy_flag || bus.rd_data != 8'h00) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL idle_quiet got %0d active cycles exp 0", act); end
    endtask

    task automatic test_data_read;
        int ec, ef, el, rc, rf, rl, fc, fa, rb;
        do_read(1'b1, 8'hA5, ec, ef, el, rc, rf, rl, fc, fa, rb);
        checks++; if (ec != 13) begin errors++; $display("FAIL data_e_len got %0d exp 13", ec); end
        checks++; if (ef != 3 || el != 15) begin errors++; $display("FAIL data_e_window got %0d..%0d exp 3..15", ef, el); end
        checks++; if (rc != 18 || rf != 0 || rl != 17) begin errors++; $display("FAIL data_rw got %0d cyc %0d..%0d exp 18 cyc 0..17", rc, rf, rl); end
        checks++; if (fc != 1 || fa != 18) begin errors++; $display("FAIL data_finish got %0d at %0d exp 1 at 18", fc, fa); end
        checks++; if (rb != 0) begin errors++; $display("FAIL data_rs got %0d bad cycles exp 0", rb); end
        checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL data_value got %h exp a5", bus.rd_data); end
        checks++; if (bus.busy_flag !== 1'b0) begin errors++; $display("FAIL data_busy got %b exp 0", bus.busy_flag); end
        checks++; if (bus.lcd_rs !== 1'b1) begin errors++; $display("FAIL data_rs_hold got %b exp 1", bus.lcd_rs); end
    endtask

    task automatic test_busy_read;
        int ec, ef, el, rc, rf, rl, fc, fa, rb;
        do_read(1'b0, 8'h80, ec, ef, el, rc, rf, rl, fc, fa, rb);
        checks++; if (bus.busy_flag !== 1'b1 || bus.rd_data !== 8'h80) begin errors++; $display("FAIL bf_set got %b/%h exp 1/80", bus.busy_flag, bus.rd_data); end
        checks++; if (fa != 18 || rb != 0) begin errors++; $display("FAIL bf_timing got fin %0d rsbad %0d exp 18/0", fa, rb); end
        do_read(1'b1, 8'h12, ec, ef, el, rc, rf, rl, fc, fa, rb);
        checks++; if (bus.busy_flag !== 1'b1 || bus.rd_data !== 8'h12) begin errors++; $display("FAIL bf_keep got %b/%h exp 1/12", bus.busy_flag, bus.rd_data); end
        do_read(1'b0, 8'h03, ec, ef, el, rc, rf, rl, fc, fa, rb);
        checks++; if (bus.busy_flag !== 1'b0 || bus.rd_data !== 8'h03) begin errors++; $display("FAIL bf_clear got %b/%h exp 0/03", bus.busy_flag, bus.rd_data); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int fa [3];
        logic [7:0] dat [3];
        logic rsv [3];
        logic bfv [3];
        int exp_fa [3] = '{18, 38, 58};
        logic [7:0] exp_dat [3] = '{8'h81, 8'h84, 8'h11};
        logic exp_rs [3] = '{1'b1, 1'b0, 1'b1};
        logic exp_bf [3] = '{1'b0, 1'b1, 1'b1};
        bus.rd_enable = 1'b1; bus.rs_in = 1'b1; bus.lcd_db_in = 8'h81;
        @(posedge clk);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (k == 8)  begin bus.rs_in = 1'b0; bus.rd_enable = 1'b0; end
            if (k == 10) bus.rd_enable = 1'b1;
            if (k == 25) bus.lcd_db_in = 8'h84;
            if (k == 28) begin bus.rs_in = 1'b1; bus.rd_enable = 1'b0; end
            if (k == 30) bus.rd_enable = 1'b1;
            if (k == 45) bus.lcd_db_in = 8'h11;
            if (k == 48) begin bus.rs_in = 1'b0; bus.rd_enable = 1'b0; end
            if (k == 50) bus.rd_enable = 1'b1;
            if (k == 52) bus.rd_enable = 1'b0;
            if (bus.rd_finish) begin
                if (n < 3) begin fa[n] = k; dat[n] = bus.rd_data; rsv[n] = bus.lcd_rs; bfv[n] = bus.busy_flag; end
                n++;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
        for (int i = 0; i < 3 && i < n; i++) begin
            checks++; if (fa[i] != exp_fa[i]) begin errors++; $display("FAIL b2b_at[%0d] got %0d exp %0d", i, fa[i], exp_fa[i]); end
            checks++; if (dat[i] !== exp_dat[i] || rsv[i] !== exp_rs[i] || bfv[i] !== exp_bf[i])
                begin errors++; $display("FAIL b2b_val[%0d] got %h/%b/%b exp %h/%b/%b", i, dat[i], rsv[i], bfv[i], exp_dat[i], exp_rs[i], exp_bf[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int ec, ef, el, rc, rf, rl, fc, fa, rb;
        int act = 0;
        bus.rs_in = 1'b1; bus.lcd_db_in = 8'h5A; bus.rd_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_enable = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (bus.E_out !== 1'b1) begin errors++; $display("FAIL rmid_pre_e got %b exp 1", bus.E_out); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.E_out !== 1'b0 || bus.lcd_rw !== 1'b0) begin errors++; $display("FAIL rmid_async got e %b rw %b exp 0 0", bus.E_out, bus.lcd_rw); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.rd_finish || bus.E_out || bus.lcd_rw) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles exp 0", act); end
        checks++; if (bus.rd_data !== 8'h00 || bus.busy_flag !== 1'b0) begin errors++; $display("FAIL rmid_cleared got %h/%b exp 00/0", bus.rd_data, bus.busy_flag); end
        do_read(1'b0, 8'hC4, ec, ef, el, rc, rf, rl, fc, fa, rb);
        checks++; if (ec != 13 || ef != 3 || rc != 18 || fc != 1 || fa != 18)
            begin errors++; $display("FAIL rmid_fresh got e %0d@%0d rw %0d fin %0d@%0d exp 13@3 18 1@18", ec, ef, rc, fc, fa); end
        checks++; if (bus.rd_data !== 8'hC4 || bus.busy_flag !== 1'b1) begin errors++; $display("FAIL rmid_value got %h/%b exp c4/1", bus.rd_data, bus.busy_flag); end
    endtask

`ifdef LCD_READ_BUSY_POLL_EN
    task automatic test_poll;
        int pulses = 0, fin = 0, drop = 0;
        logic prev_e = 1'b0;
        bus.poll_busy = 1'b1; bus.rs_in = 1'b0; bus.lcd_db_in = 8'h80; bus.rd_enable = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (k == 0) bus.rd_enable = 1'b0;
            if (bus.E_out && !prev_e) pulses++;
            if (!bus.E_out && prev_e && pulses == 2) bus.lcd_db_in = 8'h00;
            prev_e = bus.E_out;
            if (!bus.lcd_rw && !bus.rd_finish && fin == 0) drop++;
            if (bus.rd_finish) fin++;
        end
        bus.poll_busy = 1'b0;
        checks++; if (pulses != 3) begin errors++; $display("FAIL poll_pulses got %0d exp 3", pulses); end
        checks++; if (fin != 1) begin errors++; $display("FAIL poll_finish got %0d exp 1", fin); end
        checks++; if (drop != 0) begin errors++; $display("FAIL poll_rw_drop got %0d exp 0", drop); end
        checks++; if (bus.busy_flag !== 1'b0) begin errors++; $display("FAIL poll_busy_final got %b exp 0", bus.busy_flag); end
    endtask
`endif

    initial begin
        test_reset;
        test_idle;
        test_data_read;
        test_busy_read;
        test_back_to_back;
        test_reset_mid;
`ifdef LCD_READ_BUSY_POLL_EN
        test_poll;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
